// File: rtl/alu_result_framer_if.sv
// Byte-stream and ALU-result bus shared by the result framer and its neighbours.
interface alu_result_framer_if #(
    parameter int unsigned OUT_WIDTH = 16
) ();
    logic [OUT_WIDTH-1:0] ALU_OUT;
    logic                 OUT_VALID;
    logic [7:0]           TX_DATA;
    logic                 TX_VALID;
    logic                 TX_READY;

    // Driver side: ALU results in, transmitter ready in, bytes observed.
    modport master (
        output ALU_OUT,
        output OUT_VALID,
        output TX_READY,
        input  TX_DATA,
        input  TX_VALID
    );

    // Framer side: consumes ALU results, produces the byte stream.
    modport slave (
        input  ALU_OUT,
        input  OUT_VALID,
        input  TX_READY,
        output TX_DATA,
        output TX_VALID
    );
endinterface

// File: rtl/alu_result_framer.sv
// ALU result framer: buffers OUT_VALID-qualified ALU words in a small FIFO and
// serialises each one LSB-first onto a valid/ready byte stream.
// Optional build macro ALU_FRAME_HDR_EN prefixes every frame with HDR_BYTE.
module alu_result_framer #(
    parameter int unsigned OUT_WIDTH  = 16,
    parameter int unsigned FIFO_DEPTH = 4
`ifdef ALU_FRAME_HDR_EN
    ,
    parameter logic [7:0]  HDR_BYTE   = 8'hA5
`endif
) (
    input  logic                  CLK,
    input  logic                  RST,
    alu_result_framer_if.slave    bus,
    input  logic                  OVF_CLR,
    output logic                  FIFO_FULL,
    output logic                  FIFO_EMPTY,
    output logic                  OVERFLOW,
    output logic                  BUSY
);
    localparam int unsigned NB    = OUT_WIDTH / 8;
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned BC_W  = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_SEND = 2'd2
    } state_t;

    logic [OUT_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;
    logic [CNT_W-1:0]     w_count_nxt;
    logic                 r_full;
    logic                 r_empty;
    logic                 r_ovf;
    logic                 w_pop;
    logic                 w_wr;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [OUT_WIDTH-1:0] r_sr;
    logic [OUT_WIDTH-1:0] w_sr_nxt;
    logic [BC_W-1:0]      r_byte_cnt;
    logic [BC_W-1:0]      w_byte_cnt_nxt;
    logic [7:0]           r_tx_data;
    logic [7:0]           w_tx_data_nxt;
    logic                 r_active;

    // The framer takes the head only from IDLE, which also gives the inter-frame bubble.
    assign w_pop = (r_state == S_IDLE) && !r_empty;
    // A full FIFO still accepts a word when the head leaves on the same edge.
    assign w_wr  = bus.OUT_VALID && (!r_full || w_pop);

    // Occupancy update; write and pop together leave it unchanged.
    always_comb begin
        w_count_nxt = r_count;
        if (w_wr && !w_pop) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else if (!w_wr && w_pop) begin
            w_count_nxt = r_count - CNT_W'(1);
        end
    end

    // Result storage; contents need no reset since pointers and count define validity.
    always_ff @(posedge CLK) begin
        if (!RST && w_wr) begin
            r_mem[r_wr_ptr] <= bus.ALU_OUT;
        end
    end

    // FIFO pointers, count and registered full/empty flags.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CNT_W'(FIFO_DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

    // Sticky drop flag; a new drop beats a simultaneous clear.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ovf <= 1'b0;
        end else if (bus.OUT_VALID && !w_wr) begin
            r_ovf <= 1'b1;
        end else if (OVF_CLR) begin
            r_ovf <= 1'b0;
        end
    end

    // Next-state, shift register and next byte-stream outputs.
    always_comb begin
        w_state_nxt    = r_state;
        w_sr_nxt       = r_sr;
        w_byte_cnt_nxt = r_byte_cnt;
        case (r_state)
            S_IDLE: begin
                if (!r_empty) begin
                    w_sr_nxt       = r_mem[r_rd_ptr];
                    w_byte_cnt_nxt = '0;
`ifdef ALU_FRAME_HDR_EN
                    w_state_nxt    = S_HDR;
`else
                    w_state_nxt    = S_SEND;
`endif
                end
            end
`ifdef ALU_FRAME_HDR_EN
            S_HDR: begin
                if (bus.TX_READY) begin
                    w_state_nxt = S_SEND;
                end
            end
`endif
            S_SEND: begin
                if (bus.TX_READY) begin
                    w_sr_nxt       = r_sr >> 8;
                    w_byte_cnt_nxt = r_byte_cnt + BC_W'(1);
                    if (r_byte_cnt == BC_W'(NB - 1)) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
`ifdef ALU_FRAME_HDR_EN
        w_tx_data_nxt = (w_state_nxt == S_HDR) ? HDR_BYTE : w_sr_nxt[7:0];
`else
        w_tx_data_nxt = w_sr_nxt[7:0];
`endif
    end

    // State register with registered byte-stream outputs; reset drops any frame.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_sr       <= '0;
            r_byte_cnt <= '0;
            r_tx_data  <= '0;
            r_active   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sr       <= w_sr_nxt;
            r_byte_cnt <= w_byte_cnt_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_active   <= (w_state_nxt != S_IDLE);
        end
    end

    assign bus.TX_DATA  = r_tx_data;
    assign bus.TX_VALID = r_active;
    assign BUSY         = r_active;
    assign FIFO_FULL    = r_full;
    assign FIFO_EMPTY   = r_empty;
    assign OVERFLOW     = r_ovf;
endmodule

// File: tb/tb_alu_result_framer.sv
// Bench for alu_result_framer: reset, latency, vector table, backpressure,
// overflow corners, mid-frame reset and a randomized scoreboard run.
module tb_alu_result_framer;
    localparam int unsigned OUT_WIDTH  = 16;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned NB         = OUT_WIDTH / 8;
`ifdef ALU_FRAME_HDR_EN
    localparam int unsigned FL         = NB + 1;
`else
    localparam int unsigned FL         = NB;
`endif

    logic CLK;
    logic RST;
    logic OVF_CLR;
    logic FIFO_FULL;
    logic FIFO_EMPTY;
    logic OVERFLOW;
    logic BUSY;

    alu_result_framer_if #(.OUT_WIDTH(OUT_WIDTH)) bus ();

    alu_result_framer #(
        .OUT_WIDTH  (OUT_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .bus        (bus),
        .OVF_CLR    (OVF_CLR),
        .FIFO_FULL  (FIFO_FULL),
        .FIFO_EMPTY (FIFO_EMPTY),
        .OVERFLOW   (OVERFLOW),
        .BUSY       (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [15:0] word;
        logic [7:0]  b0;
        logic [7:0]  b1;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic strobe(input logic [15:0] w);
        bus.ALU_OUT   = w;
        bus.OUT_VALID = 1'b1;
        tick();
        bus.OUT_VALID = 1'b0;
    endtask

    // Waits (bounded) for the next transfer and compares its byte.
    task automatic expect_byte(input string name, input logic [7:0] exp);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (bus.TX_VALID && bus.TX_READY) begin
                check(name, 32'(bus.TX_DATA), 32'(exp));
                done = 1'b1;
            end
            tick();
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: no byte transferred in time, expected %02h", name, exp);
        end
    endtask

    task automatic expect_frame(input string name, input logic [15:0] w);
`ifdef ALU_FRAME_HDR_EN
        expect_byte({name, "_hdr"}, 8'hA5);
`endif
        for (int b = 0; b < int'(NB); b++) begin
            expect_byte(name, 8'((w >> (8 * b)) & 16'h00FF));
        end
    endtask

    // Randomized run state.
    logic [7:0]  exp_q[$];
    int          outstanding;
    int          byte_in_frame;
    bit          prev_stall;
    logic [7:0]  prev_data;
    logic [15:0] rw;

    // Compares the byte transferring this cycle against the scoreboard queue.
    task automatic score_cycle();
        if (prev_stall) begin
            check("hold_valid", 32'(bus.TX_VALID), 32'd1);
            check("hold_data", 32'(bus.TX_DATA), 32'(prev_data));
        end
        if (bus.TX_VALID && bus.TX_READY) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rand_byte: unexpected byte %02h, expected none", bus.TX_DATA);
            end else begin
                check("rand_byte", 32'(bus.TX_DATA), 32'(exp_q.pop_front()));
            end
            byte_in_frame++;
            if (byte_in_frame == int'(FL)) begin
                byte_in_frame = 0;
                outstanding--;
            end
        end
        prev_stall = bus.TX_VALID && !bus.TX_READY;
        prev_data  = bus.TX_DATA;
    endtask

    initial begin
        vecs[0] = '{16'hBEEF, 8'hEF, 8'hBE};
        vecs[1] = '{16'h1234, 8'h34, 8'h12};
        vecs[2] = '{16'h0000, 8'h00, 8'h00};
        vecs[3] = '{16'hFFFF, 8'hFF, 8'hFF};
        vecs[4] = '{16'h00FF, 8'hFF, 8'h00};
        vecs[5] = '{16'hA55A, 8'h5A, 8'hA5};

        // Reset held with a live strobe: nothing may be written.
        RST           = 1'b1;
        OVF_CLR       = 1'b0;
        bus.ALU_OUT   = 16'h1234;
        bus.OUT_VALID = 1'b1;
        bus.TX_READY  = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_tx_data", 32'(bus.TX_DATA), 32'h0);
        check("rst_tx_valid", 32'(bus.TX_VALID), 32'h0);
        check("rst_full", 32'(FIFO_FULL), 32'h0);
        check("rst_empty", 32'(FIFO_EMPTY), 32'h1);
        check("rst_ovf", 32'(OVERFLOW), 32'h0);
        check("rst_busy", 32'(BUSY), 32'h0);
        RST           = 1'b0;
        bus.OUT_VALID = 1'b0;
        tick();
        check("post_rst_empty", 32'(FIFO_EMPTY), 32'h1);
        check("post_rst_valid", 32'(bus.TX_VALID), 32'h0);

        // Single-word latency: first byte presented two cycles after the strobe.
        strobe(16'hBEEF);
        check("lat_k_valid", 32'(bus.TX_VALID), 32'h0);
        check("lat_k_empty", 32'(FIFO_EMPTY), 32'h0);
        tick();
        check("lat_k1_valid", 32'(bus.TX_VALID), 32'h1);
        check("lat_k1_busy", 32'(BUSY), 32'h1);
`ifdef ALU_FRAME_HDR_EN
        check("lat_k1_data", 32'(bus.TX_DATA), 32'hA5);
`else
        check("lat_k1_data", 32'(bus.TX_DATA), 32'hEF);
`endif
        expect_frame("beef", 16'hBEEF);
        check("beef_busy", 32'(BUSY), 32'h0);
        check("beef_empty", 32'(FIFO_EMPTY), 32'h1);
        check("beef_valid", 32'(bus.TX_VALID), 32'h0);

        // Vector table of single-word frames.
        for (int v = 0; v < 6; v++) begin
            strobe(vecs[v].word);
`ifdef ALU_FRAME_HDR_EN
            expect_byte("vec_hdr", 8'hA5);
`endif
            expect_byte("vec_b0", vecs[v].b0);
            expect_byte("vec_b1", vecs[v].b1);
            check("vec_idle", 32'(BUSY), 32'h0);
        end

        // Backpressure: the second frame byte holds for five stalled cycles.
        strobe(16'hCAFE);
`ifdef ALU_FRAME_HDR_EN
        expect_byte("bp_hdr", 8'hA5);
`endif
        expect_byte("bp_b0", 8'hFE);
        bus.TX_READY = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_valid", 32'(bus.TX_VALID), 32'h1);
            check("bp_hold_data", 32'(bus.TX_DATA), 32'hCA);
            tick();
        end
        bus.TX_READY = 1'b1;
        expect_byte("bp_b1", 8'hCA);
        check("bp_idle", 32'(BUSY), 32'h0);

        // Overflow: six strobes while stalled, then a drop coinciding with a clear.
        bus.TX_READY = 1'b0;
        for (int v = 1; v <= 6; v++) begin
            strobe(16'(v));
        end
        check("ovf_full", 32'(FIFO_FULL), 32'h1);
        check("ovf_set", 32'(OVERFLOW), 32'h1);
        OVF_CLR = 1'b1;
        strobe(16'h0007);
        OVF_CLR = 1'b0;
        check("ovf_set_beats_clr", 32'(OVERFLOW), 32'h1);
        bus.TX_READY = 1'b1;
        for (int v = 1; v <= 5; v++) begin
            expect_frame("ovf_drain", 16'(v));
        end
        check("ovf_drain_empty", 32'(FIFO_EMPTY), 32'h1);
        check("ovf_drain_idle", 32'(BUSY), 32'h0);
        OVF_CLR = 1'b1;
        tick();
        OVF_CLR = 1'b0;
        check("ovf_clr", 32'(OVERFLOW), 32'h0);

        // Write into a full FIFO on the same edge as a pop is accepted.
        bus.TX_READY = 1'b0;
        for (int v = 0; v < 5; v++) begin
            strobe(16'h0011 + 16'(v));
        end
        check("wf_full", 32'(FIFO_FULL), 32'h1);
        bus.TX_READY = 1'b1;
        expect_frame("wf_first", 16'h0011);
        check("wf_bubble_idle", 32'(BUSY), 32'h0);
        check("wf_bubble_full", 32'(FIFO_FULL), 32'h1);
        strobe(16'h0016);
        check("wf_no_ovf", 32'(OVERFLOW), 32'h0);
        check("wf_still_full", 32'(FIFO_FULL), 32'h1);
        for (int v = 0; v < 5; v++) begin
            expect_frame("wf_drain", 16'h0012 + 16'(v));
        end
        check("wf_empty", 32'(FIFO_EMPTY), 32'h1);

        // Reset mid-frame discards it at the next edge.
        bus.TX_READY = 1'b0;
        strobe(16'hCAFE);
        tick();
        check("mr_valid_before", 32'(bus.TX_VALID), 32'h1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("mr_valid", 32'(bus.TX_VALID), 32'h0);
        check("mr_busy", 32'(BUSY), 32'h0);
        check("mr_empty", 32'(FIFO_EMPTY), 32'h1);
        bus.TX_READY = 1'b1;
        tick();

        // Randomized traffic; strobes only while the model says a slot is free.
        outstanding   = 0;
        byte_in_frame = 0;
        prev_stall    = 1'b0;
        prev_data     = '0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            bus.TX_READY = ($urandom_range(0, 9) < 7);
            rw = 16'($urandom);
            bus.ALU_OUT = rw;
            bus.OUT_VALID = (outstanding < int'(FIFO_DEPTH)) && ($urandom_range(0, 1) == 1);
            score_cycle();
            if (bus.OUT_VALID) begin
                outstanding++;
`ifdef ALU_FRAME_HDR_EN
                exp_q.push_back(8'hA5);
`endif
                for (int b = 0; b < int'(NB); b++) begin
                    exp_q.push_back(8'((rw >> (8 * b)) & 16'h00FF));
                end
            end
            tick();
        end
        bus.OUT_VALID = 1'b0;
        bus.TX_READY  = 1'b1;
        for (int i = 0; i < 300 && exp_q.size() > 0; i++) begin
            score_cycle();
            tick();
        end
        check("rand_queue_drained", 32'(exp_q.size()), 32'd0);
        check("rand_no_ovf", 32'(OVERFLOW), 32'h0);
        check("rand_idle", 32'(BUSY), 32'h0);
        check("rand_empty", 32'(FIFO_EMPTY), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
